// File: rtl/memwb_writeback_if.sv
// EX/MEM-to-MEMWB bus: pipeline slot fields, stall/flush controls and the MEMWB write triple.
// The master side is the upstream pipeline; the slave side is the writeback block.
interface memwb_writeback_if #(
    parameter int CNT_W = 32
);
    logic             exmem_valid;
    logic             exmem_reg_wr;
    logic [4:0]       exmem_rd_idx;
    logic             exmem_mem_to_reg;
    logic [2:0]       exmem_load_type;
    logic [31:0]      exmem_alu_result;
    logic [31:0]      mem_rdata;
    logic             stall;
    logic             flush;

    logic             memwb_reg_wr;
    logic [4:0]       memwb_rd_idx;
    logic [31:0]      memwb_wdata;
    logic             memwb_valid;
    logic             misalign;
    logic [CNT_W-1:0] retire_cnt;

    modport master (
        output exmem_valid, exmem_reg_wr, exmem_rd_idx, exmem_mem_to_reg,
               exmem_load_type, exmem_alu_result, mem_rdata, stall, flush,
        input  memwb_reg_wr, memwb_rd_idx, memwb_wdata, memwb_valid,
               misalign, retire_cnt
    );

    modport slave (
        input  exmem_valid, exmem_reg_wr, exmem_rd_idx, exmem_mem_to_reg,
               exmem_load_type, exmem_alu_result, mem_rdata, stall, flush,
        output memwb_reg_wr, memwb_rd_idx, memwb_wdata, memwb_valid,
               misalign, retire_cnt
    );
endinterface

// File: rtl/memwb_writeback.sv
// MEM/WB pipeline register with load alignment/extension and a retired-write counter.
// Sole producer of the MEMWB write triple feeding the register file and forwarding logic.
module memwb_writeback #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    memwb_writeback_if.slave bus
);
    if (DATA_W != 32) begin : g_width_check
        $error("memwb_writeback supports DATA_W = 32 only");
    end

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    logic [1:0]        offs;
    logic [15:0]       half;
    logic [7:0]        byte_lane;
    logic [DATA_W-1:0] load_data;
    logic              misal_type;

    logic              valid_d;
    logic              reg_wr_d;
    logic [4:0]        rd_idx_d;
    logic [DATA_W-1:0] wdata_d;
    logic              misalign_d;

    logic              valid_q;
    logic              reg_wr_q;
    logic [4:0]        rd_idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic              misalign_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        offs = bus.exmem_alu_result[1:0];
        half = offs[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        // Big-endian lanes: offset 0 is the most significant byte.
        case (offs)
            2'b00:   byte_lane = bus.mem_rdata[31:24];
            2'b01:   byte_lane = bus.mem_rdata[23:16];
            2'b10:   byte_lane = bus.mem_rdata[15:8];
            default: byte_lane = bus.mem_rdata[7:0];
        endcase

        // Reserved codes fall through to the lw path, alignment check included.
        load_data  = bus.mem_rdata;
        misal_type = (offs != 2'b00);
        case (bus.exmem_load_type)
            LT_LH: begin
                load_data  = {{16{half[15]}}, half};
                misal_type = offs[0];
            end
            LT_LHU: begin
                load_data  = {16'h0000, half};
                misal_type = offs[0];
            end
            LT_LB: begin
                load_data  = {{24{byte_lane[7]}}, byte_lane};
                misal_type = 1'b0;
            end
            LT_LBU: begin
                load_data  = {24'h000000, byte_lane};
                misal_type = 1'b0;
            end
            default: ;
        endcase

        misalign_d = bus.exmem_valid & bus.exmem_mem_to_reg & misal_type;
        valid_d    = bus.exmem_valid;
        reg_wr_d   = bus.exmem_valid & bus.exmem_reg_wr &
                     (bus.exmem_rd_idx != 5'd0) & ~misalign_d;
        rd_idx_d   = bus.exmem_valid ? bus.exmem_rd_idx : 5'd0;
        wdata_d    = '0;
        if (bus.exmem_valid && !misalign_d) begin
            wdata_d = bus.exmem_mem_to_reg ? load_data : bus.exmem_alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            rd_idx_q   <= 5'd0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else if (bus.flush) begin
            valid_q    <= 1'b0;
            reg_wr_q   <= 1'b0;
            rd_idx_q   <= 5'd0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
        end else if (bus.stall) begin
            // Hold the slot but never repeat the misalign pulse.
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            reg_wr_q   <= reg_wr_d;
            rd_idx_q   <= rd_idx_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            if (reg_wr_d) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.memwb_valid  = valid_q;
    assign bus.memwb_reg_wr = reg_wr_q;
    assign bus.memwb_rd_idx = rd_idx_q;
    assign bus.memwb_wdata  = wdata_q;
    assign bus.misalign     = misalign_q;
    assign bus.retire_cnt   = cnt_q;
endmodule

// File: tb/tb_memwb_writeback.sv
// Scoreboard bench for memwb_writeback: a 32-bit-counter instance plus a 4-bit-counter
// instance sharing the same stimulus to exercise counter wrap.
module tb_memwb_writeback;
    logic clk;
    logic rst;

    memwb_writeback_if #(.CNT_W(32)) bus  ();
    memwb_writeback_if #(.CNT_W(4))  bus4 ();

    memwb_writeback #(.DATA_W(32), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    memwb_writeback #(.DATA_W(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    assign bus4.exmem_valid      = bus.exmem_valid;
    assign bus4.exmem_reg_wr     = bus.exmem_reg_wr;
    assign bus4.exmem_rd_idx     = bus.exmem_rd_idx;
    assign bus4.exmem_mem_to_reg = bus.exmem_mem_to_reg;
    assign bus4.exmem_load_type  = bus.exmem_load_type;
    assign bus4.exmem_alu_result = bus.exmem_alu_result;
    assign bus4.mem_rdata        = bus.mem_rdata;
    assign bus4.stall            = bus.stall;
    assign bus4.flush            = bus.flush;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        reg_wr;
        logic [4:0]  rd_idx;
        logic [31:0] wdata;
        logic        misalign;
        logic [31:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] lt, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(rd >> (8 * (3 - int'(a))));
        h = a[1] ? rd[15:0] : rd[31:16];
        if (lt == 3'd1)      return {{16{h[15]}}, h};
        else if (lt == 3'd2) return {16'h0, h};
        else if (lt == 3'd3) return {{24{b[7]}}, b};
        else if (lt == 3'd4) return {24'h0, b};
        else                 return rd;
    endfunction

    // Drive one cycle, advance the model, push the expectation, then check after the edge.
    task automatic cycle(input logic r, input logic st, input logic fl, input logic v,
                         input logic rw, input logic [4:0] rd, input logic m2r,
                         input logic [2:0] lt, input logic [31:0] alu, input logic [31:0] rdat);
        exp_t e;
        logic mis;
        bus.stall            = st;
        bus.flush            = fl;
        bus.exmem_valid      = v;
        bus.exmem_reg_wr     = rw;
        bus.exmem_rd_idx     = rd;
        bus.exmem_mem_to_reg = m2r;
        bus.exmem_load_type  = lt;
        bus.exmem_alu_result = alu;
        bus.mem_rdata        = rdat;
        rst                  = r;
        if (r) begin
            m = '{default: '0};
        end else if (fl) begin
            m.valid = 0; m.reg_wr = 0; m.rd_idx = 0; m.wdata = 0; m.misalign = 0;
        end else if (st) begin
            m.misalign = 0;
        end else begin
            if (lt == 3'd1 || lt == 3'd2)      mis = alu[0];
            else if (lt == 3'd3 || lt == 3'd4) mis = 1'b0;
            else                               mis = (alu[1:0] != 2'b00);
            mis        = v & m2r & mis;
            m.valid    = v;
            m.misalign = mis;
            m.reg_wr   = v & rw & (rd != 0) & ~mis;
            m.rd_idx   = v ? rd : 5'd0;
            m.wdata    = (!v || mis) ? 32'h0 : (m2r ? model_load(lt, alu[1:0], rdat) : alu);
            if (m.reg_wr) begin
                m.cnt  = m.cnt + 1;
                m.cnt4 = m.cnt4 + 1;
            end
        end
        e = m;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("valid",    32'(bus.memwb_valid),  32'(e.valid));
        chk("reg_wr",   32'(bus.memwb_reg_wr), 32'(e.reg_wr));
        chk("rd_idx",   32'(bus.memwb_rd_idx), 32'(e.rd_idx));
        chk("wdata",    bus.memwb_wdata,       e.wdata);
        chk("misalign", 32'(bus.misalign),     32'(e.misalign));
        chk("cnt",      bus.retire_cnt,        e.cnt);
        chk("cnt4",     32'(bus4.retire_cnt),  32'(e.cnt4));
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] res);
        cycle(0, 0, 0, 1, 1, rd, 0, 3'd0, res, 32'h0);
    endtask

    task automatic load_op(input logic [2:0] lt, input logic [4:0] rd, input logic [31:0] addr,
                           input logic [31:0] rdat);
        cycle(0, 0, 0, 1, 1, rd, 1, lt, addr, rdat);
    endtask

    localparam logic [31:0] RD = 32'h80FF_7F01;

    initial begin
        m = '{default: '0};
        rst = 1'b1;
        // Reset with arbitrary inputs driven.
        cycle(1, 0, 0, 1, 1, 5'd7, 0, 3'd0, 32'hAAAA_5555, 32'h1);
        cycle(1, 1, 1, 1, 1, 5'd9, 1, 3'd0, 32'h1001, 32'h2);
        chk("rst_wdata", bus.memwb_wdata, 32'h0);

        alu_op(5'd5, 32'h1234_5678);
        chk("alu_wdata", bus.memwb_wdata, 32'h1234_5678);
        chk("alu_cnt",   bus.retire_cnt,  32'd1);

        load_op(3'd3, 5'd2, 32'h2000, RD); chk("lb00",  bus.memwb_wdata, 32'hFFFF_FF80);
        load_op(3'd4, 5'd2, 32'h2000, RD); chk("lbu00", bus.memwb_wdata, 32'h0000_0080);
        load_op(3'd3, 5'd2, 32'h2002, RD); chk("lb10",  bus.memwb_wdata, 32'h0000_007F);
        load_op(3'd1, 5'd2, 32'h2002, RD); chk("lh10",  bus.memwb_wdata, 32'h0000_7F01);
        load_op(3'd1, 5'd2, 32'h2000, RD); chk("lh00",  bus.memwb_wdata, 32'hFFFF_80FF);
        load_op(3'd2, 5'd2, 32'h2000, RD); chk("lhu00", bus.memwb_wdata, 32'h0000_80FF);
        load_op(3'd0, 5'd2, 32'h2000, RD); chk("lw00",  bus.memwb_wdata, 32'h80FF_7F01);
        load_op(3'd4, 5'd2, 32'h2003, RD); chk("lbu11", bus.memwb_wdata, 32'h0000_0001);
        load_op(3'd3, 5'd2, 32'h2001, RD);
        load_op(3'd6, 5'd2, 32'h2000, RD); chk("rsv00", bus.memwb_wdata, 32'h80FF_7F01);
        load_op(3'd7, 5'd2, 32'h2001, RD); chk("rsv_mis", 32'(bus.misalign), 32'd1);

        // Misaligned loads: single-cycle pulse, no write.
        load_op(3'd0, 5'd8, 32'h1002, RD); chk("lw_mis", 32'(bus.misalign), 32'd1);
        alu_op(5'd4, 32'h0);               chk("lw_mis_end", 32'(bus.misalign), 32'd0);
        load_op(3'd1, 5'd8, 32'h1003, RD); chk("lh_mis", 32'(bus.memwb_reg_wr), 32'd0);
        cycle(0, 1, 0, 1, 1, 5'd8, 1, 3'd1, 32'h1003, RD);
        chk("mis_stall", 32'(bus.misalign), 32'd0);
        load_op(3'd2, 5'd8, 32'h1002, RD); chk("lhu_ok", 32'(bus.memwb_reg_wr), 32'd1);
        cycle(0, 0, 0, 0, 1, 5'd8, 1, 3'd0, 32'h1002, RD);
        chk("inv_mis", 32'(bus.misalign), 32'd0);

        // $0 suppression.
        alu_op(5'd0,  32'hDEAD_BEEF); chk("r0_wr",  32'(bus.memwb_reg_wr), 32'd0);
        alu_op(5'd31, 32'hDEAD_BEEF); chk("r31_wr", 32'(bus.memwb_reg_wr), 32'd1);

        // Stall holds, stall+flush bubbles, rst beats stall.
        alu_op(5'd3, 32'h0000_0333);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, 1, 1, 5'(10 + i), 0, 3'd0, 32'($urandom), 32'($urandom));
            chk("stall_rd", 32'(bus.memwb_rd_idx), 32'd3);
        end
        cycle(0, 1, 1, 1, 1, 5'd12, 0, 3'd0, 32'h5555_0000, 32'h0);
        chk("flush_valid", 32'(bus.memwb_valid), 32'd0);
        alu_op(5'd6, 32'h0000_0666);
        cycle(0, 0, 0, 1, 0, 5'd7, 0, 3'd0, 32'h0000_0777, 32'h0);
        cycle(1, 1, 0, 1, 1, 5'd9, 0, 3'd0, 32'h0000_0999, 32'h0);
        chk("rst_stall_cnt", bus.retire_cnt, 32'd0);

        // Random mix, then counter wrap on the 4-bit instance.
        for (int i = 0; i < 40; i++) begin
            cycle(0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 5) != 0), 1'($urandom), 5'($urandom),
                  1'($urandom), 3'($urandom_range(0, 7)), 32'($urandom), 32'($urandom));
        end
        cycle(1, 0, 0, 0, 0, 5'd0, 0, 3'd0, 32'h0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            alu_op(5'(1 + i), 32'(i));
        end
        chk("wrap4", 32'(bus4.retire_cnt), 32'd1);
        chk("cnt17", bus.retire_cnt, 32'd17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
